// File: rtl/apb_bridge_pkg.sv
// Shared types and constants for the APB bridge arbiter: FSM encoding, beat
// geometry and the default per-beat stall limit.
package apb_bridge_pkg;

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_ISSUE = 2'd1,
    ST_WAIT  = 2'd2,
    ST_RESP  = 2'd3
  } arb_state_t;

  localparam int BEAT_BYTES      = 4;
  localparam int BEATS_W         = 3;
  localparam int DEFAULT_TIMEOUT = 16;

endpackage

// File: rtl/apb_bridge_arbiter_if.sv
// Requester-side and bridge-side signals of the arbiter, bundled so the
// arbiter (master) and its environment (slave) share one connection.
interface apb_bridge_arbiter_if #(
  parameter int NUM_REQ = 2,
  parameter int ADDR_W  = 32,
  parameter int DATA_W  = 32
);
  import apb_bridge_pkg::*;

  logic [NUM_REQ-1:0]         req;
  logic [NUM_REQ-1:0]         req_write;
  logic [BEATS_W*NUM_REQ-1:0] req_beats;
  logic [ADDR_W*NUM_REQ-1:0]  req_addr;
  logic [DATA_W*NUM_REQ-1:0]  req_wdata;
  logic [NUM_REQ-1:0]         gnt;
  logic [NUM_REQ-1:0]         ack;
  logic [NUM_REQ-1:0]         err;
  logic [DATA_W-1:0]          rdata;

  logic                       br_valid;
  logic                       br_write;
  logic [ADDR_W-1:0]          br_addr;
  logic [DATA_W-1:0]          br_wdata;
  logic                       br_ready;
  logic [DATA_W-1:0]          br_rdata;

  modport master (
    input  req, req_write, req_beats, req_addr, req_wdata, br_ready, br_rdata,
    output gnt, ack, err, rdata, br_valid, br_write, br_addr, br_wdata
  );

  modport slave (
    output req, req_write, req_beats, req_addr, req_wdata, br_ready, br_rdata,
    input  gnt, ack, err, rdata, br_valid, br_write, br_addr, br_wdata
  );

endinterface

// File: rtl/apb_bridge_arbiter_rr_pick.sv
// Combinational round-robin picker: the first set request strictly after
// last_grant, wrapping around, wins.
module rr_pick #(
  parameter int N     = 2,
  parameter int IDX_W = (N > 1) ? $clog2(N) : 1
) (
  input  logic [N-1:0]     req,
  input  logic [IDX_W-1:0] last_grant,
  output logic [N-1:0]     pick,
  output logic             valid
);

  logic [IDX_W-1:0] idx;
  logic             found;

  // The previous winner is visited last, so it only wins when alone.
  always_comb begin
    pick  = '0;
    found = 1'b0;
    idx   = '0;
    for (int i = 1; i <= N; i++) begin
      idx = IDX_W'((int'(last_grant) + i) % N);
      if (!found && req[idx]) begin
        pick[idx] = 1'b1;
        found     = 1'b1;
      end
    end
  end

  assign valid = |req;

endmodule

// File: rtl/apb_bridge_arbiter.sv
// Shares one AHB-to-APB bridge among NUM_REQ requesters: round-robin grant,
// burst lock, one bridge command per beat and a per-beat stall timeout.
module apb_bridge_arbiter
  import apb_bridge_pkg::*;
#(
  parameter int NUM_REQ = 2,
  parameter int ADDR_W  = 32,
  parameter int DATA_W  = 32,
  parameter int TIMEOUT = DEFAULT_TIMEOUT
) (
  input logic                  clk,
  input logic                  hresetn,
  apb_bridge_arbiter_if.master bus
);

  localparam int IDX_W   = $clog2(NUM_REQ);
  localparam int TIMER_W = $clog2(TIMEOUT);

  logic [ADDR_W-1:0]  addr_arr  [NUM_REQ];
  logic [DATA_W-1:0]  wdata_arr [NUM_REQ];
  logic [BEATS_W-1:0] beats_arr [NUM_REQ];

  for (genvar g = 0; g < NUM_REQ; g++) begin : g_unpack
    assign addr_arr[g]  = bus.req_addr[g*ADDR_W +: ADDR_W];
    assign wdata_arr[g] = bus.req_wdata[g*DATA_W +: DATA_W];
    assign beats_arr[g] = bus.req_beats[g*BEATS_W +: BEATS_W];
  end

  arb_state_t         state;
  logic [IDX_W-1:0]   owner;
  logic [IDX_W-1:0]   last_grant;
  logic [BEATS_W-1:0] beats_l;
  logic [BEATS_W-1:0] beat;
  logic               write_l;
  logic               abort;
  logic [TIMER_W-1:0] timer;
  logic [DATA_W-1:0]  rdata_q;

  logic [NUM_REQ-1:0] pick;
  logic               pick_valid;
  logic [IDX_W-1:0]   pick_idx;
  logic [NUM_REQ-1:0] owner_oh;

  rr_pick #(.N(NUM_REQ), .IDX_W(IDX_W)) u_pick (
    .req        (bus.req),
    .last_grant (last_grant),
    .pick       (pick),
    .valid      (pick_valid)
  );

  always_comb begin
    pick_idx = '0;
    for (int i = 0; i < NUM_REQ; i++) begin
      if (pick[i]) pick_idx = IDX_W'(i);
    end
  end

  assign owner_oh  = NUM_REQ'(1) << owner;
  assign bus.rdata = rdata_q;

  // Bridge command lines are only non-zero during the single ISSUE cycle.
  always_comb begin
    bus.gnt      = '0;
    bus.ack      = '0;
    bus.err      = '0;
    bus.br_valid = 1'b0;
    bus.br_write = 1'b0;
    bus.br_addr  = '0;
    bus.br_wdata = '0;
    if (state != ST_IDLE) bus.gnt = owner_oh;
    if (state == ST_RESP) begin
      bus.ack = owner_oh;
      if (abort) bus.err = owner_oh;
    end
    if (state == ST_ISSUE) begin
      bus.br_valid = 1'b1;
      bus.br_write = write_l;
      bus.br_addr  = addr_arr[owner] + ADDR_W'(BEAT_BYTES) * ADDR_W'(beat);
      bus.br_wdata = wdata_arr[owner];
    end
  end

  always_ff @(posedge clk or negedge hresetn) begin
    if (!hresetn) begin
      state      <= ST_IDLE;
      owner      <= '0;
      last_grant <= IDX_W'(NUM_REQ - 1);
      beats_l    <= '0;
      beat       <= '0;
      write_l    <= 1'b0;
      abort      <= 1'b0;
      timer      <= '0;
      rdata_q    <= '0;
    end else begin
      case (state)
        ST_IDLE: begin
          if (pick_valid) begin
            owner   <= pick_idx;
            beats_l <= beats_arr[pick_idx];
            write_l <= bus.req_write[pick_idx];
            beat    <= '0;
            abort   <= 1'b0;
            state   <= ST_ISSUE;
          end
        end
        ST_ISSUE: begin
          timer <= '0;
          state <= ST_WAIT;
        end
        // A ready in the last allowed cycle still completes without error.
        ST_WAIT: begin
          if (bus.br_ready) begin
            rdata_q <= write_l ? '0 : bus.br_rdata;
            state   <= ST_RESP;
          end else if (timer == TIMER_W'(TIMEOUT - 1)) begin
            abort   <= 1'b1;
            rdata_q <= '0;
            state   <= ST_RESP;
          end else begin
            timer <= timer + 1'b1;
          end
        end
        ST_RESP: begin
          if (abort || beat == beats_l) begin
            last_grant <= owner;
            state      <= ST_IDLE;
          end else begin
            beat  <= beat + 1'b1;
            state <= ST_ISSUE;
          end
        end
        default: state <= ST_IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_apb_bridge_arbiter.sv
// Self-checking bench for apb_bridge_arbiter: vector table, hand-written burst,
// timeout, wrap and reset sequences, then randomized bursts against a model.
module tb_apb_bridge_arbiter;

  localparam int TMO = 16;

  logic        clk = 1'b0;
  logic        hresetn = 1'b0;
  logic [1:0]  req_v;
  logic [1:0]  wr_v;
  logic [2:0]  beats_v [2];
  logic [31:0] addr_v  [2];
  logic [31:0] wdata_v [2];
  logic        br_ready;
  logic [31:0] br_rdata;

  int total = 0;
  int bad = 0;
  int model_lg;

  typedef struct {
    logic [1:0]  req;
    logic        wr;
    logic [31:0] a0, a1, wd0, wd1;
    int          lat;
    logic [31:0] rd;
    int          own;
    logic [31:0] eaddr, ewdata;
    logic        eerr;
    logic [31:0] erdata;
  } vec_t;

  vec_t vecs [7];

  apb_bridge_arbiter_if #(.NUM_REQ(2), .ADDR_W(32), .DATA_W(32)) bus ();

  assign bus.req       = req_v;
  assign bus.req_write = wr_v;
  assign bus.req_beats = {beats_v[1], beats_v[0]};
  assign bus.req_addr  = {addr_v[1], addr_v[0]};
  assign bus.req_wdata = {wdata_v[1], wdata_v[0]};
  assign bus.br_ready  = br_ready;
  assign bus.br_rdata  = br_rdata;

  apb_bridge_arbiter #(.NUM_REQ(2), .ADDR_W(32), .DATA_W(32), .TIMEOUT(TMO)) dut (
    .clk     (clk),
    .hresetn (hresetn),
    .bus     (bus)
  );

  always #5 clk = ~clk;

  initial begin
    #1000000;
    $display("[TB] FAIL watchdog: got timeout want completion");
    $fatal(1, "[TB] watchdog expired");
  end

  task automatic check_output(input string name, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("[TB] FAIL %s: got 0x%08h want 0x%08h", name, act, exp);
    end
  endtask

  // Round-robin rule: scan upward from the previous winner, wrapping.
  function automatic int model_pick(input logic [1:0] rq, input int lg);
    for (int k = 1; k <= 2; k++) begin
      if (rq[(lg + k) % 2]) return (lg + k) % 2;
    end
    return -1;
  endfunction

  task automatic expect_idle();
    @(posedge clk); #1;
    check_output("idle_gnt", 32'(bus.gnt), 32'd0);
    check_output("idle_valid", 32'(bus.br_valid), 32'd0);
  endtask

  // One beat, starting one cycle before ISSUE and ending at the sample of RESP.
  task automatic do_beat(input int own, input logic [31:0] eaddr, input logic ewrite,
                         input logic [31:0] ewdata, input int lat, input logic [31:0] rd,
                         input logic eerr, input logic [31:0] erdata);
    logic [31:0] oh;
    oh = 32'(1) << own;
    @(posedge clk); #1;
    check_output("issue_valid", 32'(bus.br_valid), 32'd1);
    check_output("issue_gnt", 32'(bus.gnt), oh);
    check_output("issue_addr", bus.br_addr, eaddr);
    check_output("issue_write", 32'(bus.br_write), 32'(ewrite));
    check_output("issue_wdata", bus.br_wdata, ewdata);
    br_ready = 1'($urandom_range(0, 1));
    @(posedge clk); #1;
    br_ready = 1'b0;
    check_output("wait_valid", 32'(bus.br_valid), 32'd0);
    check_output("wait_addr", bus.br_addr, 32'd0);
    check_output("wait_ack", 32'(bus.ack), 32'd0);
    check_output("wait_gnt", 32'(bus.gnt), oh);
    if (lat < TMO) begin
      repeat (lat) begin @(posedge clk); #1; end
      br_ready = 1'b1;
      br_rdata = rd;
      @(posedge clk); #1;
    end else begin
      repeat (TMO - 1) begin @(posedge clk); #1; end
      check_output("no_early_abort", 32'(bus.ack), 32'd0);
      @(posedge clk); #1;
    end
    br_ready = 1'($urandom_range(0, 1));
    br_rdata = $urandom;
    check_output("resp_ack", 32'(bus.ack), oh);
    check_output("resp_err", 32'(bus.err), eerr ? oh : 32'd0);
    check_output("resp_gnt", 32'(bus.gnt), oh);
    if (!ewrite && !eerr) check_output("resp_rdata", bus.rdata, erdata);
  endtask

  task automatic apply_stimulus(input vec_t v);
    req_v      = v.req;
    wr_v       = {2{v.wr}};
    addr_v[0]  = v.a0;
    addr_v[1]  = v.a1;
    wdata_v[0] = v.wd0;
    wdata_v[1] = v.wd1;
    beats_v[0] = 3'd0;
    beats_v[1] = 3'd0;
    do_beat(v.own, v.eaddr, v.wr, v.ewdata, v.lat, v.rd, v.eerr, v.erdata);
    model_lg = v.own;
    expect_idle();
  endtask

  initial begin
    req_v    = '0;
    wr_v     = '0;
    br_ready = 1'b0;
    br_rdata = '0;
    for (int i = 0; i < 2; i++) begin
      beats_v[i] = '0;
      addr_v[i]  = '0;
      wdata_v[i] = '0;
    end

    vecs[0] = '{2'b01, 1'b1, 32'h40, 32'h0, 32'hDEADBEEF, 32'h0, 1, 32'h0,
                0, 32'h40, 32'hDEADBEEF, 1'b0, 32'h0};
    vecs[1] = '{2'b10, 1'b0, 32'h0, 32'h80, 32'h0, 32'h0, 0, 32'h12345678,
                1, 32'h80, 32'h0, 1'b0, 32'h12345678};
    vecs[2] = '{2'b11, 1'b0, 32'h200, 32'h300, 32'h0, 32'h0, 2, 32'hAAAA5555,
                0, 32'h200, 32'h0, 1'b0, 32'hAAAA5555};
    vecs[3] = '{2'b11, 1'b1, 32'h204, 32'h304, 32'h0, 32'hCAFEF00D, 15, 32'h0,
                1, 32'h304, 32'hCAFEF00D, 1'b0, 32'h0};
    vecs[4] = '{2'b11, 1'b0, 32'hFFFFFFFC, 32'h308, 32'h0, 32'h0, 16, 32'h0,
                0, 32'hFFFFFFFC, 32'h0, 1'b1, 32'h0};
    vecs[5] = '{2'b01, 1'b0, 32'h10, 32'h0, 32'h0, 32'h0, 0, 32'h0BADC0DE,
                0, 32'h10, 32'h0, 1'b0, 32'h0BADC0DE};
    vecs[6] = '{2'b11, 1'b1, 32'h14, 32'h20, 32'h0, 32'h13572468, 3, 32'h0,
                1, 32'h20, 32'h13572468, 1'b0, 32'h0};

    repeat (3) @(posedge clk);
    #1;
    check_output("rst_gnt", 32'(bus.gnt), 32'd0);
    check_output("rst_ack", 32'(bus.ack), 32'd0);
    check_output("rst_err", 32'(bus.err), 32'd0);
    check_output("rst_rdata", bus.rdata, 32'd0);
    check_output("rst_valid", 32'(bus.br_valid), 32'd0);
    check_output("rst_addr", bus.br_addr, 32'd0);
    hresetn  = 1'b1;
    model_lg = 1;
    expect_idle();

    for (int i = 0; i < 7; i++) apply_stimulus(vecs[i]);

    // Four-beat write burst; req[1] rises mid-burst and must wait its turn.
    req_v = 2'b01; wr_v = 2'b01;
    addr_v[0] = 32'h100; addr_v[1] = 32'h180;
    beats_v[0] = 3'd3; beats_v[1] = 3'd0;
    wdata_v[0] = 32'h11110000;
    for (int b = 0; b < 4; b++) begin
      do_beat(0, 32'h100 + 32'(4 * b), 1'b1, wdata_v[0], 0, 32'h0, 1'b0, 32'h0);
      if (b == 0) req_v[1] = 1'b1;
      wdata_v[0] = wdata_v[0] + 32'd1;
    end
    expect_idle();
    do_beat(1, 32'h180, 1'b0, wdata_v[1], 1, 32'h5A5A0001, 1'b0, 32'h5A5A0001);
    expect_idle();

    // Timeout on beat 1 abandons the rest of the burst.
    req_v = 2'b01; wr_v = 2'b00;
    addr_v[0] = 32'h400; beats_v[0] = 3'd3;
    do_beat(0, 32'h400, 1'b0, wdata_v[0], 0, 32'h77, 1'b0, 32'h77);
    do_beat(0, 32'h404, 1'b0, wdata_v[0], TMO, 32'h0, 1'b1, 32'h0);
    expect_idle();

    // Burst address wraps past the top of the address space.
    req_v = 2'b10; wr_v = 2'b10;
    addr_v[1] = 32'hFFFFFFF8; beats_v[1] = 3'd3;
    for (int b = 0; b < 4; b++) begin
      do_beat(1, 32'hFFFFFFF8 + 32'(4 * b), 1'b1, wdata_v[1], 1, 32'h0, 1'b0, 32'h0);
    end
    expect_idle();

    // Reset during WAIT of beat 2; last winner was requester 0.
    req_v = 2'b01; wr_v = 2'b00;
    addr_v[0] = 32'h600; beats_v[0] = 3'd0;
    do_beat(0, 32'h600, 1'b0, wdata_v[0], 0, 32'h66, 1'b0, 32'h66);
    expect_idle();
    addr_v[0] = 32'h500; beats_v[0] = 3'd3;
    do_beat(0, 32'h500, 1'b0, wdata_v[0], 0, 32'hA5A50000, 1'b0, 32'hA5A50000);
    do_beat(0, 32'h504, 1'b0, wdata_v[0], 0, 32'hA5A50001, 1'b0, 32'hA5A50001);
    @(posedge clk); #1;
    check_output("rst_issue_addr", bus.br_addr, 32'h508);
    br_ready = 1'b0;
    @(posedge clk); #1;
    hresetn = 1'b0;
    #1;
    check_output("midrst_gnt", 32'(bus.gnt), 32'd0);
    check_output("midrst_ack", 32'(bus.ack), 32'd0);
    check_output("midrst_err", 32'(bus.err), 32'd0);
    check_output("midrst_rdata", bus.rdata, 32'd0);
    check_output("midrst_valid", 32'(bus.br_valid), 32'd0);
    check_output("midrst_addr", bus.br_addr, 32'd0);
    req_v = 2'b11; beats_v[0] = 3'd0; beats_v[1] = 3'd0;
    repeat (2) @(posedge clk);
    #1;
    hresetn  = 1'b1;
    model_lg = 1;
    do_beat(0, 32'h500, 1'b0, wdata_v[0], 0, 32'h0F0F0F0F, 1'b0, 32'h0F0F0F0F);
    model_lg = 0;
    expect_idle();

    // Randomized bursts checked against the transaction-level model.
    for (int n = 0; n < 40; n++) begin
      int own;
      int nb;
      int lat;
      logic [31:0] rd;
      req_v = 2'($urandom_range(1, 3));
      for (int i = 0; i < 2; i++) begin
        wr_v[i]    = 1'($urandom_range(0, 1));
        beats_v[i] = 3'($urandom_range(0, 3));
        addr_v[i]  = ($urandom_range(0, 3) == 0) ? 32'hFFFFFFF8 : ($urandom & 32'hFFFFFFFC);
        wdata_v[i] = $urandom;
      end
      own = model_pick(req_v, model_lg);
      nb  = int'(beats_v[own]) + 1;
      for (int b = 0; b < nb; b++) begin
        case ($urandom_range(0, 9))
          0:       lat = TMO;
          1:       lat = TMO - 1;
          default: lat = int'($urandom_range(0, 4));
        endcase
        rd = $urandom;
        do_beat(own, addr_v[own] + 32'(4 * b), wr_v[own], wdata_v[own], lat, rd,
                (lat >= TMO), rd);
        if (lat >= TMO) break;
        wdata_v[own] = $urandom;
        if ($urandom_range(0, 3) == 0) req_v[own] = 1'b0;
      end
      model_lg = own;
      expect_idle();
    end

    req_v = '0;
    repeat (2) @(posedge clk);
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
